wavelet_len_table: RTL
======================

Name: wavelet_len_table

Overview:
- Sequential, parametrised successor to the core's combinational length decoder.
- On a configuration start pulse it computes per-level input, absolute and output lengths for up to MAX_LEVELS decomposition levels, one level per clock, into a register table.
- It also computes the output-buffer approximation and last-output addresses, and flags buffer overflow.
- The controller reads the table through a registered query port indexed by the current decomposition level.

Parameters:
- IBUFF_CELL_COUNT, 2048, input buffer depth in cells.
- OBUFF_CELL_COUNT, 2048, output buffer depth in cells.
- MAX_LEVELS, 8, maximum number of decomposition levels (>=2).
- IBUFF_ADDR_WIDTH, $clog2(IBUFF_CELL_COUNT), input buffer address width.
- OBUFF_ADDR_WIDTH, $clog2(OBUFF_CELL_COUNT), output buffer address width.
- LVL_WIDTH, $clog2(MAX_LEVELS), level index width.
- LEN_WIDTH, IBUFF_ADDR_WIDTH+1, length width; a full buffer is representable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_start  in  1  one-cycle pulse; latch the cfg_* inputs and begin calculation.
- cfg_dec_level  in  LVL_WIDTH  index of the last level (level count = value+1).
- cfg_inputs_len  in  LEN_WIDTH  raw signal length at level 0, 1..IBUFF_CELL_COUNT.
- cfg_filter_size  in  IBUFF_ADDR_WIDTH  filter taps.
- cfg_downsample  in  1  1 = output length is input length >>1.
- cfg_busy  out  1  calculation in progress.
- tbl_valid  out  1  table complete and error-free.
- cfg_error  out  1  overflow detected; table is invalid.
- rd_level  in  LVL_WIDTH  query level.
- rd_init  in  1  initialisation-phase query.
- rd_inputs_len  out  LEN_WIDTH  input length incl. filter extension.
- rd_inputs_len_abs  out  LEN_WIDTH  length before filter extension.
- rd_outputs_len  out  LEN_WIDTH  output length of rd_level.
- rd_prev_outputs_len  out  LEN_WIDTH  output length of rd_level-1; level 0 returns level 0.
- rd_oob  out  1  rd_level > latched cfg_dec_level.
- obuff_w_approx_addr  out  OBUFF_ADDR_WIDTH+1  sum of out_len[0..dec_level].
- obuff_last_output  out  OBUFF_ADDR_WIDTH+1  obuff_w_approx_addr + out_len[dec_level].

Behaviour:
- Reset: FSM enters IDLE; all table entries, rd_* outputs, addresses, busy, valid and error are 0.
- FSM states: IDLE, CALC, DONE, ERR.
  - cfg_start is accepted in every state. It latches config, clears the table, valid, error and the accumulator, sets lvl=0 and enters CALC.
  - A start during CALC restarts the calculation; the old progress is discarded.
- CALC, per cycle for level lvl:
  - abs = (lvl==0) ? cfg_inputs_len : out_len[lvl-1].
  - in_len = abs + filter.
  - out_len = downsample ? in_len>>1 (floor) : in_len.
  - acc += out_len.
  - Result is written at the clock edge.
- Overflow, checked at full width (no wrap-around):
  - in_len > IBUFF_CELL_COUNT, or acc + out_len[dec_level] > OBUFF_CELL_COUNT, sends the FSM to ERR.
  - In ERR: cfg_error=1, tbl_valid=0, cfg_busy=0, until the next start or reset.
- Completion:
  - When lvl == cfg_dec_level is written without error, the next state is DONE. obuff_w_approx_addr and obuff_last_output are registered on that same edge.
  - Latency: tbl_valid rises cfg_dec_level+1 cycles after the start edge, plus one cycle for the last-output compare.
  - cfg_busy = 1 exactly while in CALC.
- Read port: all rd_* outputs are registered with a 1-cycle latency from rd_level/rd_init, in every state.
  - rd_init=1: rd_inputs_len = (filter<<1)+2 and the other rd fields follow rd_level. This overrides table lookup.
  - rd_oob=1: rd_inputs_len, rd_inputs_len_abs and rd_outputs_len are 0.
  - Reads while tbl_valid=0 return the current table contents; they are meaningful only for already-written levels.
- Mid-operation reset: the FSM immediately returns to the reset state above.

Decomposition:
- Shared package wavelet_pkg holds:
  - the state enum len_state_t (IDLE, CALC, DONE, ERR);
  - the len_entry_t struct {abs, in_len, out_len};
  - LEN_WIDTH as a derived function of the buffer depth.
- One combinational sub-module, wavelet_len_step: abs, filter and downsample in; in_len, out_len and ovf out. Reused by the init-mode path.

Test Plan:
- Length 256, filter 8, downsample, dec_level 1 -> levels {in 264, out 132}, {abs 132, in 140, out 70}; approx 202, last 272; tbl_valid after 3 cycles.
- Length 1024, filter 4, no downsample, dec_level 3 -> accumulator exceeds 2048 at level 1 -> cfg_error=1, tbl_valid=0, cfg_busy=0.
- Length 2048, filter 16, downsample, dec_level 0 -> in_len 2064 > 2048 -> ERR; then a start with length 2032 -> in 2048, out 1024, approx 1024, last 2048, valid.
- Restart during CALC (second start at level 2 with dec_level 0, length 512, filter 2, downsample) -> out 257, approx 257, last 514; no stale levels.
- rd_init=1 with filter 10 -> rd_inputs_len 22 one cycle later; rd_level=5 with dec_level 2 -> rd_oob=1, lengths 0.
- rst asserted mid-CALC -> all outputs 0 next cycle, state IDLE; a subsequent start computes correctly.

Source files
------------

// File: rtl/wavelet_pkg.sv
// Shared types for the wavelet length table: FSM states, per-level table entry,
// and the rule that turns a buffer depth into a length width.
package wavelet_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE,
      ERR
   } len_state_t;

   // One extra bit over the address width so a completely full buffer fits.
   function automatic int len_width(input int cells);
      return $clog2(cells) + 1;
   endfunction

   localparam int DEF_IBUFF_CELL_COUNT = 2048;
   localparam int PKG_LEN_WIDTH        = len_width(DEF_IBUFF_CELL_COUNT);

   typedef struct packed {
      logic [PKG_LEN_WIDTH-1:0] abs;
      logic [PKG_LEN_WIDTH-1:0] in_len;
      logic [PKG_LEN_WIDTH-1:0] out_len;
   } len_entry_t;

endpackage

// File: rtl/wavelet_len_step.sv
// One decomposition step: extends a length by the filter taps, optionally halves it,
// and flags when the extended length no longer fits in the input buffer.
module wavelet_len_step
   import wavelet_pkg::*;
#(
   parameter int IBUFF_CELL_COUNT = 2048,
   parameter int LEN_WIDTH        = len_width(IBUFF_CELL_COUNT),
   parameter int FILT_WIDTH       = LEN_WIDTH - 1
) (
   input  logic [LEN_WIDTH-1:0]  abs,
   input  logic [FILT_WIDTH-1:0] filter,
   input  logic                  downsample,
   output logic [LEN_WIDTH-1:0]  in_len,
   output logic [LEN_WIDTH-1:0]  out_len,
   output logic                  ovf
);

   localparam logic [LEN_WIDTH:0] IBUFF_LIMIT = (LEN_WIDTH+1)'(IBUFF_CELL_COUNT);

   logic [LEN_WIDTH:0] sum;

   // The sum keeps its carry bit so the overflow compare never sees a wrapped value.
   always_comb begin
      sum     = {1'b0, abs} + (LEN_WIDTH+1)'(filter);
      in_len  = sum[LEN_WIDTH-1:0];
      out_len = downsample ? sum[LEN_WIDTH:1] : sum[LEN_WIDTH-1:0];
      ovf     = (sum > IBUFF_LIMIT);
   end

endmodule

// File: rtl/wavelet_len_table.sv
// Per-level length table for the wavelet core: after cfg_start it fills one
// decomposition level per clock and serves registered lookups to the controller.
module wavelet_len_table
   import wavelet_pkg::*;
#(
   parameter int IBUFF_CELL_COUNT = 2048,
   parameter int OBUFF_CELL_COUNT = 2048,
   parameter int MAX_LEVELS       = 8,
   parameter int IBUFF_ADDR_WIDTH = $clog2(IBUFF_CELL_COUNT),
   parameter int OBUFF_ADDR_WIDTH = $clog2(OBUFF_CELL_COUNT),
   parameter int LVL_WIDTH        = $clog2(MAX_LEVELS),
   parameter int LEN_WIDTH        = len_width(IBUFF_CELL_COUNT)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_start,
   input  logic [LVL_WIDTH-1:0]        cfg_dec_level,
   input  logic [LEN_WIDTH-1:0]        cfg_inputs_len,
   input  logic [IBUFF_ADDR_WIDTH-1:0] cfg_filter_size,
   input  logic                        cfg_downsample,
   output logic                        cfg_busy,
   output logic                        tbl_valid,
   output logic                        cfg_error,
   input  logic [LVL_WIDTH-1:0]        rd_level,
   input  logic                        rd_init,
   output logic [LEN_WIDTH-1:0]        rd_inputs_len,
   output logic [LEN_WIDTH-1:0]        rd_inputs_len_abs,
   output logic [LEN_WIDTH-1:0]        rd_outputs_len,
   output logic [LEN_WIDTH-1:0]        rd_prev_outputs_len,
   output logic                        rd_oob,
   output logic [OBUFF_ADDR_WIDTH:0]   obuff_w_approx_addr,
   output logic [OBUFF_ADDR_WIDTH:0]   obuff_last_output,
   output len_state_t                  dbg_state
);

   localparam int ADDR_MAX  = (OBUFF_ADDR_WIDTH > IBUFF_ADDR_WIDTH) ? OBUFF_ADDR_WIDTH
                                                                    : IBUFF_ADDR_WIDTH;
   localparam int ACC_WIDTH = ADDR_MAX + 3;
   localparam logic [ACC_WIDTH-1:0] OBUFF_LIMIT = ACC_WIDTH'(OBUFF_CELL_COUNT);

   len_state_t state_q, state_d;

   logic [LVL_WIDTH-1:0]        lvl_q;
   logic [LVL_WIDTH-1:0]        dec_q;
   logic [LEN_WIDTH-1:0]        len_q;
   logic [IBUFF_ADDR_WIDTH-1:0] filt_q;
   logic                        ds_q;
   logic [ACC_WIDTH-1:0]        acc_q;
   logic [ACC_WIDTH-1:0]        last_q;
   logic [OBUFF_ADDR_WIDTH:0]   approx_q;
   logic                        valid_q;
   len_entry_t                  tbl [MAX_LEVELS];

   logic [LEN_WIDTH-1:0] abs_cur;
   logic [LEN_WIDTH-1:0] step_in;
   logic [LEN_WIDTH-1:0] step_out;
   logic                 step_ovf;
   logic [ACC_WIDTH-1:0] acc_next;
   logic [ACC_WIDTH-1:0] last_next;
   logic                 step_err;
   logic                 last_ovf;

   logic [LEN_WIDTH-1:0] init_abs;
   logic [LEN_WIDTH-1:0] init_in_len;
   logic [LEN_WIDTH-1:0] init_out_unused;
   logic                 init_ovf_unused;

   logic                 rd_oob_d;
   logic [LVL_WIDTH-1:0] rd_prev_idx;

   // Protocol: cfg_start is a single-cycle pulse accepted in any state. cfg_busy is high
   // exactly while levels are being computed; afterwards exactly one of tbl_valid and
   // cfg_error rises and holds until the next start or reset.
   assign cfg_busy            = (state_q == CALC);
   assign cfg_error           = (state_q == ERR);
   assign tbl_valid           = valid_q;
   assign obuff_w_approx_addr = approx_q;
   assign obuff_last_output   = last_q[OBUFF_ADDR_WIDTH:0];
   assign dbg_state           = state_q;

   assign abs_cur  = (lvl_q == '0) ? len_q : tbl[lvl_q - 1'b1].out_len;
   assign init_abs = LEN_WIDTH'(filt_q) + LEN_WIDTH'(2);

   wavelet_len_step #(
      .IBUFF_CELL_COUNT (IBUFF_CELL_COUNT),
      .LEN_WIDTH        (LEN_WIDTH),
      .FILT_WIDTH       (IBUFF_ADDR_WIDTH)
   ) u_step (
      .abs        (abs_cur),
      .filter     (filt_q),
      .downsample (ds_q),
      .in_len     (step_in),
      .out_len    (step_out),
      .ovf        (step_ovf)
   );

   // Initialisation query length (filter<<1)+2 is one step applied to filter+2.
   wavelet_len_step #(
      .IBUFF_CELL_COUNT (IBUFF_CELL_COUNT),
      .LEN_WIDTH        (LEN_WIDTH),
      .FILT_WIDTH       (IBUFF_ADDR_WIDTH)
   ) u_init_step (
      .abs        (init_abs),
      .filter     (filt_q),
      .downsample (1'b0),
      .in_len     (init_in_len),
      .out_len    (init_out_unused),
      .ovf        (init_ovf_unused)
   );

   always_comb begin
      acc_next  = acc_q + ACC_WIDTH'(step_out);
      last_next = acc_next + ACC_WIDTH'(step_out);
      step_err  = step_ovf || (acc_next > OBUFF_LIMIT);
      last_ovf  = (last_q > OBUFF_LIMIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (cfg_start) begin
         state_d = CALC;
      end else begin
         case (state_q)
            CALC: begin
               if (step_err) begin
                  state_d = ERR;
               end else if (lvl_q == dec_q) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               if (!valid_q && last_ovf) begin
                  state_d = ERR;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q    <= '0;
         dec_q    <= '0;
         len_q    <= '0;
         filt_q   <= '0;
         ds_q     <= 1'b0;
         acc_q    <= '0;
         last_q   <= '0;
         approx_q <= '0;
         valid_q  <= 1'b0;
         for (int i = 0; i < MAX_LEVELS; i++) begin
            tbl[i] <= '0;
         end
      end else if (cfg_start) begin
         lvl_q    <= '0;
         dec_q    <= cfg_dec_level;
         len_q    <= cfg_inputs_len;
         filt_q   <= cfg_filter_size;
         ds_q     <= cfg_downsample;
         acc_q    <= '0;
         last_q   <= '0;
         approx_q <= '0;
         valid_q  <= 1'b0;
         for (int i = 0; i < MAX_LEVELS; i++) begin
            tbl[i] <= '0;
         end
      end else if (state_q == CALC) begin
         tbl[lvl_q] <= '{abs: abs_cur, in_len: step_in, out_len: step_out};
         acc_q      <= acc_next;
         lvl_q      <= lvl_q + 1'b1;
         if (!step_err && (lvl_q == dec_q)) begin
            approx_q <= acc_next[OBUFF_ADDR_WIDTH:0];
            last_q   <= last_next;
         end
      end else if ((state_q == DONE) && !valid_q && !last_ovf) begin
         valid_q <= 1'b1;
      end
   end

   always_comb begin
      rd_oob_d    = (rd_level > dec_q);
      rd_prev_idx = (rd_level == '0) ? rd_level : rd_level - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_inputs_len       <= '0;
         rd_inputs_len_abs   <= '0;
         rd_outputs_len      <= '0;
         rd_prev_outputs_len <= '0;
         rd_oob              <= 1'b0;
      end else begin
         rd_oob              <= rd_oob_d;
         rd_prev_outputs_len <= tbl[rd_prev_idx].out_len;
         if (rd_oob_d) begin
            rd_inputs_len_abs <= '0;
            rd_outputs_len    <= '0;
         end else begin
            rd_inputs_len_abs <= tbl[rd_level].abs;
            rd_outputs_len    <= tbl[rd_level].out_len;
         end
         if (rd_init) begin
            rd_inputs_len <= init_in_len;
         end else if (rd_oob_d) begin
            rd_inputs_len <= '0;
         end else begin
            rd_inputs_len <= tbl[rd_level].in_len;
         end
      end
   end

endmodule
